// File: rtl/cpu_pkg.sv
// Widths and fetch-state encoding shared by the CPU front end (fetch and decode).
package cpu_pkg;

   localparam int N = 32;
   localparam int M = 16;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_RESP = 2'd1,
      S_FULL = 2'd2,
      S_HALT = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: instruction memory read port, decoder handshake and control-flow inputs.
interface instr_fetch_if #(
   parameter int N = cpu_pkg::N,
   parameter int M = cpu_pkg::M
);
   logic         imem_req;
   logic [M-1:0] imem_addr;
   logic [N-1:0] imem_rdata;
   logic [N-1:0] instr;
   logic         instr_valid;
   logic         instr_ready;
   logic [M-1:0] instr_pc;
   logic         redirect;
   logic [M-1:0] redirect_target;
   logic         halt;
   logic         halted;

   modport master (
      output imem_req, imem_addr, instr, instr_valid, instr_pc, halted,
      input  imem_rdata, instr_ready, redirect, redirect_target, halt
   );

   modport slave (
      input  imem_req, imem_addr, instr, instr_valid, instr_pc, halted,
      output imem_rdata, instr_ready, redirect, redirect_target, halt
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: one read in flight, a single-entry output buffer, redirect and sticky halt.
module instr_fetch #(
   parameter int           N        = cpu_pkg::N,
   parameter int           M        = cpu_pkg::M,
   parameter logic [M-1:0] RESET_PC = {M{1'b0}}
) (
   input logic           clk,
   input logic           rst,
   instr_fetch_if.master bus
);
   import cpu_pkg::*;

   fetch_state_e state_r, state_s;
   logic [M-1:0] fetch_pc_r, fetch_pc_s;
   logic [N-1:0] instr_r, instr_s;
   logic [M-1:0] instr_pc_r, instr_pc_s;
   logic         instr_valid_r, instr_valid_s;
   logic         halted_r, halted_s;
   logic         imem_req_s;

   // State and PC registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= S_REQ;
         fetch_pc_r    <= RESET_PC;
         instr_r       <= {N{1'b0}};
         instr_pc_r    <= {M{1'b0}};
         instr_valid_r <= 1'b0;
         halted_r      <= 1'b0;
      end else begin
         state_r       <= state_s;
         fetch_pc_r    <= fetch_pc_s;
         instr_r       <= instr_s;
         instr_pc_r    <= instr_pc_s;
         instr_valid_r <= instr_valid_s;
         halted_r      <= halted_s;
      end
   end

   // Next state: halt beats redirect, redirect beats both the capture and the handshake.
   always_comb begin
      state_s       = state_r;
      fetch_pc_s    = fetch_pc_r;
      instr_s       = instr_r;
      instr_pc_s    = instr_pc_r;
      instr_valid_s = instr_valid_r;
      halted_s      = halted_r;
      if (state_r == S_HALT) begin
         instr_valid_s = 1'b0;
      end else if (bus.halt) begin
         state_s       = S_HALT;
         halted_s      = 1'b1;
         instr_valid_s = 1'b0;
      end else if (bus.redirect) begin
         state_s       = S_REQ;
         fetch_pc_s    = bus.redirect_target;
         instr_valid_s = 1'b0;
      end else begin
         case (state_r)
            S_REQ: begin
               state_s = S_RESP;
            end
            S_RESP: begin
               instr_s       = bus.imem_rdata;
               instr_pc_s    = fetch_pc_r;
               fetch_pc_s    = fetch_pc_r + {{(M-1){1'b0}}, 1'b1};
               instr_valid_s = 1'b1;
               state_s       = S_FULL;
            end
            S_FULL: begin
               if (bus.instr_ready) begin
                  instr_valid_s = 1'b0;
                  state_s       = S_REQ;
               end else begin
                  state_s = S_FULL;
               end
            end
            default: begin
               state_s = S_REQ;
            end
         endcase
      end
   end

   // Read strobe decoded from state, suppressed while reset is held.
   always_comb begin
      if (rst) begin
         imem_req_s = 1'b0;
      end else if (state_r == S_REQ) begin
         imem_req_s = 1'b1;
      end else begin
         imem_req_s = 1'b0;
      end
   end

   assign bus.imem_req    = imem_req_s;
   assign bus.imem_addr   = fetch_pc_r;
   assign bus.instr       = instr_r;
   assign bus.instr_pc    = instr_pc_r;
   assign bus.instr_valid = instr_valid_r;
   assign bus.halted      = halted_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed table, corner sequences, randomized run against a model.
module tb_instr_fetch;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   instr_fetch_if #(.N(32), .M(16)) bus0 ();
   instr_fetch_if #(.N(32), .M(16)) bus1 ();

   instr_fetch #(.N(32), .M(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   instr_fetch #(.N(32), .M(16), .RESET_PC(16'hFFFF)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      return 32'h0C000000 + {16'h0000, a};
   endfunction

   // Instruction memories: data one cycle after the request, garbage otherwise.
   always @(posedge clk) begin
      if (bus0.imem_req) bus0.imem_rdata <= mem_word(bus0.imem_addr);
      else               bus0.imem_rdata <= $urandom;
      if (bus1.imem_req) bus1.imem_rdata <= mem_word(bus1.imem_addr);
      else               bus1.imem_rdata <= $urandom;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an outstanding read, a buffered word, and a halt flag.
   logic [15:0] m_pc;
   logic        m_pending, m_have, m_halted;
   logic [31:0] m_instr;
   logic [15:0] m_ipc;

   task automatic model_reset();
      m_pc = 16'h0000; m_pending = 1'b0; m_have = 1'b0; m_halted = 1'b0;
      m_instr = 32'h0; m_ipc = 16'h0;
   endtask

   task automatic model_step();
      if (rst) begin
         model_reset();
      end else if (m_halted) begin
         m_halted = 1'b1;
      end else if (bus0.halt) begin
         m_halted = 1'b1; m_have = 1'b0; m_pending = 1'b0;
      end else if (bus0.redirect) begin
         m_pc = bus0.redirect_target; m_have = 1'b0; m_pending = 1'b0;
      end else if (m_have) begin
         if (bus0.instr_ready) m_have = 1'b0;
      end else if (m_pending) begin
         m_instr = mem_word(m_pc); m_ipc = m_pc; m_pc = m_pc + 16'd1;
         m_have = 1'b1; m_pending = 1'b0;
      end else begin
         m_pending = 1'b1;
      end
   endtask

   task automatic clear_inputs();
      bus0.instr_ready = 1'b1; bus0.redirect = 1'b0;
      bus0.redirect_target = 16'h0000; bus0.halt = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_req",     {31'd0, bus0.imem_req},    32'd0);
      chk("rst_addr",    {16'd0, bus0.imem_addr},   32'h0000);
      chk("rst_instr",   bus0.instr,                32'h0);
      chk("rst_pc",      {16'd0, bus0.instr_pc},    32'h0);
      chk("rst_valid",   {31'd0, bus0.instr_valid}, 32'd0);
      chk("rst_halted",  {31'd0, bus0.halted},      32'd0);
      chk("rst1_addr",   {16'd0, bus1.imem_addr},   32'hFFFF);
      model_reset();
      rst = 1'b0;
   endtask

   typedef struct {
      logic        ready;
      logic        exp_req;
      logic [15:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_instr;
      logic [15:0] exp_pc;
      logic        exp1_req;
      logic [15:0] exp1_addr;
   } vec_t;

   function automatic vec_t mk(input logic rdy, input logic req, input logic [15:0] addr,
                               input logic vld, input logic [15:0] ipc);
      vec_t v;
      v.ready = rdy; v.exp_req = req; v.exp_addr = addr; v.exp_valid = vld;
      v.exp_instr = mem_word(ipc); v.exp_pc = ipc;
      v.exp1_req = 1'b0; v.exp1_addr = 16'h0000;
      return v;
   endfunction

   vec_t vecs[17];

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      clear_inputs();
      bus1.instr_ready = 1'b1; bus1.redirect = 1'b0;
      bus1.redirect_target = 16'h0000; bus1.halt = 1'b0;

      // Three back-to-back fetches, then a five-cycle stall on the third word.
      vecs[0]  = mk(1'b1, 1'b1, 16'd0, 1'b0, 16'd0);
      vecs[1]  = mk(1'b1, 1'b0, 16'd0, 1'b0, 16'd0);
      vecs[2]  = mk(1'b1, 1'b0, 16'd1, 1'b1, 16'd0);
      vecs[3]  = mk(1'b1, 1'b1, 16'd1, 1'b0, 16'd0);
      vecs[4]  = mk(1'b1, 1'b0, 16'd1, 1'b0, 16'd0);
      vecs[5]  = mk(1'b1, 1'b0, 16'd2, 1'b1, 16'd1);
      vecs[6]  = mk(1'b1, 1'b1, 16'd2, 1'b0, 16'd0);
      vecs[7]  = mk(1'b1, 1'b0, 16'd2, 1'b0, 16'd0);
      vecs[8]  = mk(1'b0, 1'b0, 16'd3, 1'b1, 16'd2);
      vecs[9]  = mk(1'b0, 1'b0, 16'd3, 1'b1, 16'd2);
      vecs[10] = mk(1'b0, 1'b0, 16'd3, 1'b1, 16'd2);
      vecs[11] = mk(1'b0, 1'b0, 16'd3, 1'b1, 16'd2);
      vecs[12] = mk(1'b0, 1'b0, 16'd3, 1'b1, 16'd2);
      vecs[13] = mk(1'b1, 1'b0, 16'd3, 1'b1, 16'd2);
      vecs[14] = mk(1'b1, 1'b1, 16'd3, 1'b0, 16'd0);
      vecs[15] = mk(1'b1, 1'b0, 16'd3, 1'b0, 16'd0);
      vecs[16] = mk(1'b1, 1'b0, 16'd4, 1'b1, 16'd3);
      // The FFFF-reset instance runs unstalled: a request every third cycle, wrapping to 0000.
      for (int i = 0; i < 17; i++) begin
         vecs[i].exp1_req  = ((i % 3) == 0);
         vecs[i].exp1_addr = 16'hFFFF + 16'((i + 1) / 3);
      end

      do_reset();
      for (int i = 0; i < 17; i++) begin
         bus0.instr_ready = vecs[i].ready;
         #1;
         chk($sformatf("tbl%0d_req", i),   {31'd0, bus0.imem_req},    {31'd0, vecs[i].exp_req});
         chk($sformatf("tbl%0d_addr", i),  {16'd0, bus0.imem_addr},   {16'd0, vecs[i].exp_addr});
         chk($sformatf("tbl%0d_valid", i), {31'd0, bus0.instr_valid}, {31'd0, vecs[i].exp_valid});
         if (vecs[i].exp_valid) begin
            chk($sformatf("tbl%0d_instr", i), bus0.instr, vecs[i].exp_instr);
            chk($sformatf("tbl%0d_ipc", i),   {16'd0, bus0.instr_pc}, {16'd0, vecs[i].exp_pc});
         end
         chk($sformatf("tbl%0d_req1", i),  {31'd0, bus1.imem_req},  {31'd0, vecs[i].exp1_req});
         chk($sformatf("tbl%0d_addr1", i), {16'd0, bus1.imem_addr}, {16'd0, vecs[i].exp1_addr});
         @(negedge clk);
      end

      // Redirect while the read is in flight: the returning word is dropped.
      clear_inputs();
      #1;
      chk("redir_pre_req",  {31'd0, bus0.imem_req},  32'd1);
      chk("redir_pre_addr", {16'd0, bus0.imem_addr}, 32'h0004);
      @(negedge clk);
      bus0.redirect = 1'b1; bus0.redirect_target = 16'h0040;
      #1;
      chk("redir_resp_req", {31'd0, bus0.imem_req}, 32'd0);
      @(negedge clk);
      bus0.redirect = 1'b0;
      #1;
      chk("redir_req",   {31'd0, bus0.imem_req},    32'd1);
      chk("redir_addr",  {16'd0, bus0.imem_addr},   32'h0040);
      chk("redir_valid", {31'd0, bus0.instr_valid}, 32'd0);
      @(negedge clk);
      #1;
      chk("redir_resp_valid", {31'd0, bus0.instr_valid}, 32'd0);
      @(negedge clk);
      #1;
      chk("redir_full_valid", {31'd0, bus0.instr_valid}, 32'd1);
      chk("redir_instr",      bus0.instr,                32'h0C000040);
      chk("redir_ipc",        {16'd0, bus0.instr_pc},    32'h0040);

      // Halt and redirect together in the full state: halt wins and sticks.
      bus0.halt = 1'b1; bus0.redirect = 1'b1; bus0.redirect_target = 16'h1234;
      @(negedge clk);
      clear_inputs();
      #1;
      chk("halt_halted", {31'd0, bus0.halted},      32'd1);
      chk("halt_valid",  {31'd0, bus0.instr_valid}, 32'd0);
      chk("halt_addr",   {16'd0, bus0.imem_addr},   32'h0041);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         bus0.instr_ready = 1'($urandom_range(0, 1));
         bus0.redirect    = 1'($urandom_range(0, 1));
         bus0.redirect_target = 16'($urandom);
         bus0.halt        = 1'($urandom_range(0, 1));
         #1;
         chk($sformatf("halt%0d_req", c),    {31'd0, bus0.imem_req},    32'd0);
         chk($sformatf("halt%0d_halted", c), {31'd0, bus0.halted},      32'd1);
         chk($sformatf("halt%0d_valid", c),  {31'd0, bus0.instr_valid}, 32'd0);
      end

      // Reset releases the halt and restarts at the reset address.
      @(negedge clk);
      clear_inputs();
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("unhalt_halted", {31'd0, bus0.halted},   32'd0);
      chk("unhalt_req_rst", {31'd0, bus0.imem_req}, 32'd0);
      rst = 1'b0;
      #1;
      chk("unhalt_req",  {31'd0, bus0.imem_req},  32'd1);
      chk("unhalt_addr", {16'd0, bus0.imem_addr}, 32'h0000);
      @(negedge clk);

      // Randomized run against the model.
      do_reset();
      for (int c = 0; c < 800; c++) begin
         rst                  = ($urandom_range(0, 59) == 0);
         bus0.instr_ready     = ($urandom_range(0, 3) != 0);
         bus0.redirect        = ($urandom_range(0, 7) == 0);
         bus0.redirect_target = 16'($urandom);
         bus0.halt            = ($urandom_range(0, 99) == 0);
         #1;
         chk("rnd_req",    {31'd0, bus0.imem_req},
             {31'd0, (!rst && !m_halted && !m_pending && !m_have)});
         chk("rnd_addr",   {16'd0, bus0.imem_addr},   {16'd0, m_pc});
         chk("rnd_valid",  {31'd0, bus0.instr_valid}, {31'd0, m_have});
         chk("rnd_halted", {31'd0, bus0.halted},      {31'd0, m_halted});
         if (m_have) begin
            chk("rnd_instr", bus0.instr, m_instr);
            chk("rnd_ipc",   {16'd0, bus0.instr_pc}, {16'd0, m_ipc});
         end
         model_step();
         @(negedge clk);
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
